button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 168 ++++++++++++++++
 tb/tb_button_conditioner.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Per-channel debouncer with press/release/long-press/auto-repeat pulses; all outputs registered.
// Press/release appear DB_CYCLES+2 edges after a raw level change; no backpressure, pulses are one cycle.
module button_conditioner #(
  parameter int               N_BTN         = 5,
  parameter int               DB_CYCLES     = 20,
  parameter int               LONG_CYCLES   = 1000,
  parameter int               REPEAT_CYCLES = 200,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = N_BTN'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int HW  = $clog2(LONG_CYCLES + 1);
  localparam int RPW = $clog2(REPEAT_CYCLES + 1);

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_TERM = HW'(LONG_CYCLES);
  localparam logic [HW-1:0]  HOLD_PRE  = HW'(LONG_CYCLES - 1);
  localparam logic [RPW-1:0] REP_LAST  = RPW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_HELD,
    S_RELEASE_WAIT
  } state_t;

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    state_t         r_state, w_state_nxt;
    logic [DBW-1:0] r_db, w_db_nxt;
    logic [HW-1:0]  r_hold, w_hold_nxt;
    logic [RPW-1:0] r_rep, w_rep_nxt;
    logic           r_level, w_level_nxt;
    logic           r_press, w_press_nxt;
    logic           r_release, w_release_nxt;
    logic           r_long, w_long_nxt;
    logic           r_repeat, w_repeat_nxt;
    logic           w_sync;

    assign w_sync = r_sync2[g];

    always_comb begin
      w_state_nxt   = r_state;
      w_db_nxt      = r_db;
      w_hold_nxt    = r_hold;
      w_rep_nxt     = r_rep;
      w_level_nxt   = r_level;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      w_long_nxt    = 1'b0;
      w_repeat_nxt  = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_sync) begin
            w_state_nxt = S_PRESS_WAIT;
            w_db_nxt    = DBW'(1);
          end
        end
        S_PRESS_WAIT: begin
          if (!w_sync) begin
            w_state_nxt = S_IDLE;
            w_db_nxt    = '0;
          end else if (r_db == DB_LAST) begin
            w_state_nxt = S_HELD;
            w_db_nxt    = '0;
            w_level_nxt = 1'b1;
            w_press_nxt = 1'b1;
            w_hold_nxt  = '0;
            w_rep_nxt   = '0;
          end else begin
            w_db_nxt = r_db + DBW'(1);
          end
        end
        S_HELD: begin
          if (!w_sync) begin
            w_state_nxt = S_RELEASE_WAIT;
            w_db_nxt    = DBW'(1);
          end
        end
        S_RELEASE_WAIT: begin
          if (w_sync) begin
            w_state_nxt = S_HELD;
            w_db_nxt    = '0;
          end else if (r_db == DB_LAST) begin
            w_state_nxt   = S_IDLE;
            w_db_nxt      = '0;
            w_level_nxt   = 1'b0;
            w_release_nxt = 1'b1;
            w_hold_nxt    = '0;
            w_rep_nxt     = '0;
          end else begin
            w_db_nxt = r_db + DBW'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase

      // Hold time only accrues on cycles the button reads pressed, so a bounce freezes it.
      if ((r_state == S_HELD || r_state == S_RELEASE_WAIT) && w_sync) begin
        if (r_hold != HOLD_TERM) begin
          w_hold_nxt = r_hold + HW'(1);
          w_long_nxt = (r_hold == HOLD_PRE);
        end else if (REPEAT_MASK[g]) begin
          if (r_rep == REP_LAST) begin
            w_rep_nxt    = '0;
            w_repeat_nxt = 1'b1;
          end else begin
            w_rep_nxt = r_rep + RPW'(1);
          end
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state   <= S_IDLE;
        r_db      <= '0;
        r_hold    <= '0;
        r_rep     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        r_repeat  <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_db      <= w_db_nxt;
        r_hold    <= w_hold_nxt;
        r_rep     <= w_rep_nxt;
        r_level   <= w_level_nxt;
        r_press   <= w_press_nxt;
        r_release <= w_release_nxt;
        r_long    <= w_long_nxt;
        r_repeat  <= w_repeat_nxt;
      end
    end

    assign btn_level[g]   = r_level;
    assign btn_press[g]   = r_press;
    assign btn_release[g] = r_release;
    assign btn_long[g]    = r_long;
    assign btn_repeat[g]  = r_repeat;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: run-length debounce model checked every cycle, plus directed timing pins.
module tb_button_conditioner;

  localparam int         N    = 5;
  localparam int         DB   = 4;
  localparam int         LONG = 10;
  localparam int         REP  = 3;
  localparam logic [4:0] MASK = 5'b00001;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_long, btn_repeat;

  int vectors     = 0;
  int miscompares = 0;

  button_conditioner #(
    .N_BTN(N), .DB_CYCLES(DB), .LONG_CYCLES(LONG),
    .REPEAT_CYCLES(REP), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .btn_repeat(btn_repeat)
  );

  always #5 clk = ~clk;

  // Model: a level flips after DB consecutive disagreeing samples of the 2-cycle-delayed input;
  // held time counts pressed samples after the press, long at LONG, repeats every REP beyond it.
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_w = '0;
  logic [N-1:0] m_level = '0, m_press = '0, m_rel = '0, m_long = '0, m_rep = '0;
  int           m_run [N];
  int           m_held[N];

  initial begin
    for (int c = 0; c < N; c++) begin
      m_run[c]  = 0;
      m_held[c] = 0;
    end
  end

  always @(posedge clk) begin
    m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_level = '0;
      for (int c = 0; c < N; c++) begin
        m_run[c]  = 0;
        m_held[c] = 0;
      end
    end else begin
      m_w  = m_s2;
      m_s2 = m_s1;
      m_s1 = btn_raw;
      for (int c = 0; c < N; c++) begin
        if (m_w[c] != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] == DB) begin
            m_run[c]   = 0;
            m_level[c] = m_w[c];
            m_held[c]  = 0;
            if (m_w[c]) m_press[c] = 1'b1;
            else        m_rel[c]   = 1'b1;
          end
        end else begin
          m_run[c] = 0;
          if (m_level[c]) begin
            m_held[c]++;
            if (m_held[c] == LONG) m_long[c] = 1'b1;
            else if (m_held[c] > LONG && MASK[c] && ((m_held[c] - LONG) % REP) == 0) m_rep[c] = 1'b1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_level",   btn_level,   rst ? '0 : m_level);
    check("model_press",   btn_press,   rst ? '0 : m_press);
    check("model_release", btn_release, rst ? '0 : m_rel);
    check("model_long",    btn_long,    rst ? '0 : m_long);
    check("model_repeat",  btn_repeat,  rst ? '0 : m_rep);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int p0, l0, l4, fr0, rc0, rc4, np3, nr3, lo3, l3, fp;
  logic [N-1:0] acc;

  initial begin
    idle(2);
    check("reset_outputs", btn_level | btn_press | btn_release | btn_long | btn_repeat, '0);
    rst = 1'b0;
    idle(3);

    // single press on channel 1: pulse on the 6th sampled edge
    btn_raw[1] = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      check_int($sformatf("press1_t%0d", t), int'(btn_press[1]), (t == 6) ? 1 : 0);
      if (t >= 6) check_int($sformatf("level1_t%0d", t), int'(btn_level[1]), 1);
    end
    btn_raw[1] = 1'b0;
    idle(10);
    check_int("level1_released", int'(btn_level[1]), 0);

    // 3-cycle glitch on channel 2 must produce nothing
    btn_raw[2] = 1'b1;
    idle(3);
    btn_raw[2] = 1'b0;
    acc = '0;
    for (int t = 0; t < 10; t++) begin
      tick();
      acc |= btn_level | btn_press | btn_release | btn_long | btn_repeat;
    end
    check("glitch_quiet", acc, '0);

    // long press + auto-repeat on masked ch0, unmasked ch4
    p0 = 0; l0 = 0; l4 = 0; fr0 = 0; rc0 = 0; rc4 = 0;
    btn_raw[0] = 1'b1; btn_raw[4] = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (btn_press[0]) p0 = t;
      if (btn_long[0])  l0 = t;
      if (btn_long[4])  l4 = t;
      if (btn_repeat[0]) begin
        rc0++;
        if (fr0 == 0) fr0 = t;
      end
      if (btn_repeat[4]) rc4++;
    end
    check_int("press0_tick", p0, 6);
    check_int("long0_tick", l0, 16);
    check_int("long4_tick", l4, 16);
    check_int("first_repeat0_tick", fr0, 19);
    check_int("repeat0_count", rc0, 4);
    check_int("repeat4_count", rc4, 0);
    btn_raw[0] = 1'b0; btn_raw[4] = 1'b0;
    idle(10);

    // held ch3 with a 2-cycle low bounce: long shifts by two cycles
    np3 = 0; nr3 = 0; lo3 = 0; l3 = 0;
    btn_raw[3] = 1'b1;
    for (int t = 1; t <= 24; t++) begin
      tick();
      if (btn_press[3])   np3++;
      if (btn_release[3]) nr3++;
      if (t >= 6 && !btn_level[3]) lo3++;
      if (btn_long[3]) l3 = t;
      if (t == 8)  btn_raw[3] = 1'b0;
      if (t == 10) btn_raw[3] = 1'b1;
    end
    check_int("bounce_presses", np3, 1);
    check_int("bounce_releases", nr3, 0);
    check_int("bounce_level_low", lo3, 0);
    check_int("bounce_long_tick", l3, 18);
    btn_raw[3] = 1'b0;
    idle(10);

    // simultaneous ch0/ch3 press, then reset mid-hold and re-debounce
    btn_raw[0] = 1'b1; btn_raw[3] = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 6) check("dual_press", btn_press, 5'b01001);
    end
    rst = 1'b1;
    #1;
    check("async_reset_level", btn_level, '0);
    acc = '0;
    for (int t = 0; t < 3; t++) begin
      tick();
      acc |= btn_level | btn_press | btn_release | btn_long | btn_repeat;
    end
    check("during_reset_quiet", acc, '0);
    rst = 1'b0;
    fp = 0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (btn_press != '0 && fp == 0) fp = t;
      if (t == 6) check("repress_vector", btn_press, 5'b01001);
    end
    check_int("repress_tick", fp, 6);
    check("repress_level", btn_level, 5'b01001);
    btn_raw = '0;
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
